// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: requester/mux-control bundle for mux_rr_arbiter.
// The lock signal exists only when MUX_ARB_LOCK_EN is defined.
interface mux_rr_arbiter_if #(
  parameter int DW = 8
);
  logic [3:0]    req;
  logic [DW-1:0] din0;
  logic [DW-1:0] din1;
  logic [DW-1:0] din2;
  logic [DW-1:0] din3;
`ifdef MUX_ARB_LOCK_EN
  logic          lock;
`endif
  logic [3:0]    gnt;
  logic          sel1;
  logic          sel2;
  logic [DW-1:0] dout;
  logic          dout_vld;
  logic          busy;

`ifdef MUX_ARB_LOCK_EN
  modport master (
    output req, din0, din1, din2, din3, lock,
    input  gnt, sel1, sel2, dout, dout_vld, busy
  );
  modport slave (
    input  req, din0, din1, din2, din3, lock,
    output gnt, sel1, sel2, dout, dout_vld, busy
  );
`else
  modport master (
    output req, din0, din1, din2, din3,
    input  gnt, sel1, sel2, dout, dout_vld, busy
  );
  modport slave (
    input  req, din0, din1, din2, din3,
    output gnt, sel1, sel2, dout, dout_vld, busy
  );
`endif
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin burst-limited arbiter driving a 4:1 mux tree.
// Optional grant lock (no burst release while held): MUX_ARB_LOCK_EN.
module mux_rr_arbiter #(
  parameter int DW        = 8,
  parameter int BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_rr_arbiter_if.slave  bus
);
  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW:0] BMAX = (CW+1)'(BURST_MAX);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e        state_q;
  logic [1:0]    ptr_q;
  logic [1:0]    g_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]    gnt_q;
  logic          sel1_q;
  logic          sel2_q;
  logic [DW-1:0] dout_q;
  logic          vld_q;

  logic          win_vld;
  logic [1:0]    win_idx;
  logic [DW-1:0] din_sel;
  logic          xfer;
  logic          others;
  logic          at_lim;
  logic          lock_on;
  logic          rel;
  logic          grant_new;
  logic          drop;
  logic          hold_x;
  logic [CW:0]   cnt_inc;
  logic [CW-1:0] cnt_d;

  // Lowest offset from ptr wins; loop runs high-to-low so it lands last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[ptr_q + 2'(k)]) begin
        win_vld = 1'b1;
        win_idx = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    din_sel = bus.din0;
    unique case (g_q)
      2'd0: din_sel = bus.din0;
      2'd1: din_sel = bus.din1;
      2'd2: din_sel = bus.din2;
      2'd3: din_sel = bus.din3;
      default: din_sel = bus.din0;
    endcase
  end

`ifdef MUX_ARB_LOCK_EN
  assign lock_on = bus.lock;
`else
  assign lock_on = 1'b0;
`endif

  assign xfer    = (state_q == GRANT) && bus.req[g_q];
  assign others  = |(bus.req & ~(4'b0001 << g_q));
  assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);
  assign at_lim  = (cnt_inc >= BMAX);

  assign rel = !bus.req[g_q]
             || (xfer && at_lim && others && !lock_on);

  assign grant_new = win_vld
                   && ((state_q == IDLE)
                   || ((state_q == GRANT) && rel));
  assign drop   = (state_q == GRANT) && rel && !win_vld;
  assign hold_x = xfer && !rel;

  // Lock keeps cnt pinned at the limit so dropping lock releases at once.
  always_comb begin
    cnt_d = cnt_inc[CW-1:0];
    if (at_lim) begin
      if (lock_on) begin
        cnt_d = BMAX[CW-1:0];
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      g_q     <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 4'b0000;
      sel1_q  <= 1'b0;
      sel2_q  <= 1'b0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      vld_q <= xfer;
      if (xfer) begin
        dout_q <= din_sel;
      end
      unique case (1'b1)
        grant_new: begin
          state_q <= GRANT;
          g_q     <= win_idx;
          gnt_q   <= 4'b0001 << win_idx;
          sel1_q  <= win_idx[0];
          sel2_q  <= win_idx[1];
          ptr_q   <= win_idx + 2'd1;
          cnt_q   <= '0;
        end
        drop: begin
          state_q <= IDLE;
          gnt_q   <= 4'b0000;
        end
        hold_x: begin
          cnt_q <= cnt_d;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.sel1     = sel1_q;
  assign bus.sel2     = sel2_q;
  assign bus.dout     = dout_q;
  assign bus.dout_vld = vld_q;
  assign bus.busy     = (state_q == GRANT);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed vectors and corner sequences for mux_rr_arbiter.
// Lock behaviour is exercised when MUX_ARB_LOCK_EN is defined.
module tb_mux_rr_arbiter;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mux_rr_arbiter_if #(.DW(8)) bus ();

  mux_rr_arbiter #(
    .DW(8),
    .BURST_MAX(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       sel2;
    logic       sel1;
    logic [7:0] dout;
    logic       vld;
    logic       busy;
  } vec_t;

  vec_t       tbl [16];
  logic [7:0] dv  [4];

  function automatic logic [15:0] obs();
    return {bus.gnt, bus.sel2, bus.sel1,
            bus.dout, bus.dout_vld, bus.busy};
  endfunction

  function automatic logic [15:0] mk(
    logic [3:0] g, logic s2, logic s1,
    logic [7:0] d, logic v, logic b);
    return {g, s2, s1, d, v, b};
  endfunction

  task automatic chk(string nm, logic [15:0] act,
                     logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = 4'b0000;
`ifdef MUX_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    #3;
    chk("reset_state", obs(), 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    dv[0]    = 8'h11;
    dv[1]    = 8'h22;
    dv[2]    = 8'hA5;
    dv[3]    = 8'hC3;
    bus.din0 = dv[0];
    bus.din1 = dv[1];
    bus.din2 = dv[2];
    bus.din3 = dv[3];
`ifdef MUX_ARB_LOCK_EN
    bus.lock = 1'b0;
`endif

    //         req      gnt      s2    s1    dout   vld   busy
    tbl[0]  = '{4'b0100, 4'b0100, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[1]  = '{4'b0100, 4'b0100, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1};
    tbl[2]  = '{4'b0100, 4'b0100, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1};
    tbl[3]  = '{4'b0100, 4'b0100, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1};
    tbl[4]  = '{4'b0100, 4'b0100, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1};
    tbl[5]  = '{4'b0100, 4'b0100, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1};
    tbl[6]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    tbl[7]  = '{4'b1001, 4'b1000, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1};
    tbl[8]  = '{4'b1001, 4'b1000, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1};
    tbl[9]  = '{4'b0001, 4'b0001, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1};
    tbl[10] = '{4'b0001, 4'b0001, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1};
    tbl[11] = '{4'b0000, 4'b0000, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0};
    tbl[12] = '{4'b0010, 4'b0010, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1};
    tbl[13] = '{4'b0010, 4'b0010, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1};
    tbl[14] = '{4'b1001, 4'b1000, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1};
    tbl[15] = '{4'b1001, 4'b1000, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1};

    // Table: single requester, idle, switches and pointer order.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus.req = tbl[i].req;
      step();
      chk($sformatf("vec%0d", i), obs(),
          mk(tbl[i].gnt, tbl[i].sel2, tbl[i].sel1,
             tbl[i].dout, tbl[i].vld, tbl[i].busy));
    end

    // Reset asserted mid-burst clears outputs without a clock edge.
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 6; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midburst_rst", obs(), 16'h0000);
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 4'b0100;
    step();
    chk("post_rst_grant", obs(),
        mk(4'b0100, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1));

    // Full contention: 4 transfers per grant, no dout_vld gaps.
    do_reset();
    bus.req = 4'b1111;
    for (int n = 1; n <= 21; n++) begin
      int         gi;
      int         di;
      logic [1:0] gb;
      step();
      gi = ((n - 1) / 4) % 4;
      gb = 2'(gi);
      if (n == 1) begin
        chk($sformatf("cont_e%0d", n), obs(),
            mk(4'b0001 << gi, gb[1], gb[0],
               8'h00, 1'b0, 1'b1));
      end else begin
        di = ((n - 2) / 4) % 4;
        chk($sformatf("cont_e%0d", n), obs(),
            mk(4'b0001 << gi, gb[1], gb[0],
               dv[di], 1'b1, 1'b1));
      end
    end

    // Early release: one dead cycle before the grant moves.
    do_reset();
    bus.req = 4'b1001;
    step();
    step();
    step();
    chk("early_e3", obs(),
        mk(4'b0001, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1));
    bus.req = 4'b1000;
    step();
    chk("early_e4", obs(),
        mk(4'b1000, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1));
    step();
    chk("early_e5", obs(),
        mk(4'b1000, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1));

    // Burst limit between two requesters, with and without lock.
    do_reset();
    bus.req = 4'b0011;
`ifdef MUX_ARB_LOCK_EN
    bus.lock = 1'b1;
    for (int i = 0; i < 11; i++) step();
    chk("lock_held", obs(),
        mk(4'b0001, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1));
    bus.lock = 1'b0;
    step();
    chk("lock_drop", obs(),
        mk(4'b0010, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1));
    step();
    chk("lock_next", obs(),
        mk(4'b0010, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1));
`else
    for (int i = 0; i < 4; i++) step();
    chk("burst_e4", obs(),
        mk(4'b0001, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1));
    step();
    chk("burst_e5", obs(),
        mk(4'b0010, 1'b0, 1'b1, 8'h11, 1'b1, 1'b1));
    step();
    chk("burst_e6", obs(),
        mk(4'b0010, 1'b0, 1'b1, 8'h22, 1'b1, 1'b1));
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
